bit_demux32: RTL
================

# bit_demux32

- Write-side counterpart of the processor's 32:1 bit multiplexer: assembles a 32-bit word from individually addressed single-bit writes.
- Each accepted write drops one bit into the lane given by a 5-bit select; a per-lane written-mask tracks progress.
- A word is handed off on a valid/ready output port when all 32 lanes are written, or earlier on a flush.
- Sits between bit-serial producers (field/flag scatter, serial ingress) and word-wide consumers in the processor datapath.

## Interface
Parameters: none (width fixed at 32, select at 5 bits).

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset, sampled on clk_i rising edge
- bit_valid_i  in  1  bit write request
- bit_ready_o  out  1  block can accept a bit write this cycle
- sel_i  in  5  destination lane, 0..31
- bit_i  in  1  bit value to write
- flush_i  in  1  close the current partial word (single-cycle request)
- word_valid_o  out  1  output word held
- word_ready_i  in  1  consumer accepts word
- word_o  out  32  assembled word; unwritten lanes read 0
- word_mask_o  out  32  lanes written in word_o (all ones for a full word)
- dup_err_o  out  1  sticky duplicate-write flag (only with BIT_DEMUX32_DUPERR_EN, else tied 0)

## Operation
- Storage:
  - Accumulator: acc_r[31:0], mask_r[31:0], acc_full_r.
  - Output register: word_o, word_mask_o, word_valid_o.
- Write fire = bit_valid_i && bit_ready_o.
  - Sets acc_r[sel_i] = bit_i and mask_r[sel_i] = 1.
  - Rewriting an already-written lane overwrites the value; the mask is unchanged.
- bit_ready_o = !acc_full_r.
- Close event: next mask (mask_r | onehot on fire) equals all ones, or flush_i = 1 with next mask nonzero.
  - flush_i with an empty next mask is ignored; no empty word is ever produced.
  - A fire and flush_i in the same cycle: the bit is included, then the word closes.
- Output slot is free when !word_valid_o || word_ready_i.
- On close with the slot free:
  - Load word_o = next acc and word_mask_o = next mask; set word_valid_o.
  - Clear acc_r and mask_r to 0.
- On close with the slot busy:
  - Hold the data in the accumulator and set acc_full_r.
  - Writes stall (bit_ready_o = 0).
- State acc_full_r = 1: on the first cycle the slot is free, transfer acc to the output, clear the accumulator, and clear acc_full_r.
  - flush_i is ignored while acc_full_r = 1.
- Output handshake: word_valid_o && word_ready_i pops the word.
  - word_valid_o drops unless a new word loads on the same edge.
  - word_o and word_mask_o hold steady while word_valid_o && !word_ready_i.
- Effective states:
  - FILL (acc_full_r = 0)
  - BLOCKED (acc_full_r = 1)
  - Output EMPTY or HELD, orthogonal to the above.

## Timing
- Reset values: word_valid_o=0, word_o=0, word_mask_o=0, bit_ready_o=1, dup_err_o=0, acc_r=0, mask_r=0, acc_full_r=0.
- Latency: the fire that closes a word at edge N gives word_valid_o=1 after edge N (1 cycle) when the slot is free.
- Back-to-back: a pop and a new close on the same edge yield continuous word_valid_o with the new data.
- Throughput: one bit per cycle in FILL; a full word every 32 cycles with no stall if the consumer pops within 32 cycles.
- rst_i mid-word or with a word held: everything is discarded and returns to reset values on that edge; inputs are ignored during reset.
- bit_ready_o is combinational from acc_full_r only; there is no path from word_ready_i to bit_ready_o.

## Configuration
- BIT_DEMUX32_DUPERR_EN defined:
  - dup_err_o sets when a fire targets a lane whose mask_r bit is already 1.
  - It stays set until rst_i.
  - The data write still occurs.
- BIT_DEMUX32_DUPERR_EN undefined: no detection logic; dup_err_o is constant 0.

## Test plan
- Write lanes 0..31 in order with bit_i = lane[0] -> word_valid_o one cycle after the 32nd fire, word_o=32'hAAAAAAAA, word_mask_o=32'hFFFFFFFF.
- Write lanes 3 and 7 with 1, then flush_i -> word_o=32'h00000088, word_mask_o=32'h00000088; flush_i alone afterwards produces no word.
- Hold word_ready_i=0, complete two full words (all ones, then all zeros) -> bit_ready_o=0 after the second closes; raising word_ready_i pops 32'hFFFFFFFF, then 32'h00000000 on the next cycle, and bit_ready_o returns to 1.
- Write lane 5 with 1, then 0, then flush -> word_o=32'h0, word_mask_o=32'h20; dup_err_o=1 with BIT_DEMUX32_DUPERR_EN, 0 without.
- Assert rst_i after 10 writes with a word held -> next cycle word_valid_o=0 and bit_ready_o=1; a new full word contains only post-reset writes.
- Random lane order with random stalls on word_ready_i, checked against a scoreboard model -> every word and mask matches, none lost or duplicated.

Source files
------------

// File: rtl/bit_demux32.sv
// Assembles a 32-bit word from single-bit lane writes; word appears 1 cycle after the closing fire.
// Writes stall (bit_ready_o=0) only while a closed word waits behind a held output. Option: BIT_DEMUX32_DUPERR_EN.
module bit_demux32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bit_valid_i,
  output logic        bit_ready_o,
  input  logic [4:0]  sel_i,
  input  logic        bit_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [31:0] word_mask_o,
  output logic        dup_err_o
);

  logic [31:0] acc_r;
  logic [31:0] mask_r;
  logic        acc_full_r;

  logic        fire;
  logic [31:0] onehot;
  logic [31:0] nxt_acc;
  logic [31:0] nxt_mask;
  logic        slot_free;
  logic        close_evt;

  assign bit_ready_o = !acc_full_r;
  assign fire        = bit_valid_i && !acc_full_r;
  assign onehot      = 32'd1 << sel_i;
  assign slot_free   = !word_valid_o || word_ready_i;

  always_comb begin
    nxt_acc  = acc_r;
    nxt_mask = mask_r;
    if (fire) begin
      nxt_acc  = bit_i ? (acc_r | onehot) : (acc_r & ~onehot);
      nxt_mask = mask_r | onehot;
    end
  end

  // A flush never closes an empty word, and is ignored while a word is parked.
  assign close_evt = !acc_full_r &&
                     ((nxt_mask == 32'hFFFF_FFFF) || (flush_i && (nxt_mask != 32'd0)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r        <= 32'd0;
      mask_r       <= 32'd0;
      acc_full_r   <= 1'b0;
      word_valid_o <= 1'b0;
      word_o       <= 32'd0;
      word_mask_o  <= 32'd0;
    end else begin
      if (word_valid_o && word_ready_i) begin
        word_valid_o <= 1'b0;
      end
      if (acc_full_r) begin
        if (slot_free) begin
          word_o       <= acc_r;
          word_mask_o  <= mask_r;
          word_valid_o <= 1'b1;
          acc_r        <= 32'd0;
          mask_r       <= 32'd0;
          acc_full_r   <= 1'b0;
        end
      end else if (close_evt && slot_free) begin
        word_o       <= nxt_acc;
        word_mask_o  <= nxt_mask;
        word_valid_o <= 1'b1;
        acc_r        <= 32'd0;
        mask_r       <= 32'd0;
      end else begin
        // Closing into a busy slot parks the word here until the consumer pops.
        acc_r      <= nxt_acc;
        mask_r     <= nxt_mask;
        acc_full_r <= close_evt;
      end
    end
  end

`ifdef BIT_DEMUX32_DUPERR_EN
  logic dup_err_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dup_err_r <= 1'b0;
    end else if (fire && mask_r[sel_i]) begin
      dup_err_r <= 1'b1;
    end
  end

  assign dup_err_o = dup_err_r;
`else
  assign dup_err_o = 1'b0;
`endif

endmodule
